// File: rtl/fir_cap_pkg.sv
// Shared defaults and state encoding for the FIR result capture block.
package fir_cap_pkg;

  localparam int FC_DATA_W = 22;
  localparam int FC_DEPTH  = 252;
  localparam int FC_ADDR_W = 8;
  localparam int FC_SKIP   = 8;
  localparam int FC_ERR_W  = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SKIP    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/fir_cap_ram.sv
// Simple dual-port RAM: synchronous write, registered read.
// A read that hits the address being written returns the previous contents.
module fir_cap_ram #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 252,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] array [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic wr_ok, rd_ok;
  assign wr_ok = we_i && ({1'b0, waddr_i} < DEPTH_X);
  assign rd_ok = {1'b0, raddr_i} < DEPTH_X;

  // Storage write; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) array[waddr_i] <= wdata_i;
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rdata_q <= '0;
    else if (rd_ok) rdata_q <= array[raddr_i];
    else            rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_result_capture.sv
// Collects filter output samples after the pipeline fill, stores them in a
// capture RAM and compares each against a preloaded expected-vector RAM.
module fir_result_capture
  import fir_cap_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int DEPTH  = FC_DEPTH,
  parameter int ADDR_W = FC_ADDR_W,
  parameter int SKIP   = FC_SKIP,
  parameter int ERR_W  = FC_ERR_W
) (
  input  logic              clk100,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   cap_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err
);

  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  cap_state_e        state_q;
  logic [SKIP_W-1:0] skip_q;
  logic [ADDR_W-1:0] wptr_q;
  logic              busy_q, done_q;

  // compare stage 1 holds the accepted sample; expected word comes from EXP_MEM
  logic              s1_vld_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [ADDR_W-1:0] s1_idx_q;
  logic [DATA_W-1:0] exp_rd;

  logic [ADDR_W:0]   cap_cnt_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic [ADDR_W-1:0] first_err_q;

  logic idle_or_done, run_start, cap_acc, exp_wr;
  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign run_start    = start && idle_or_done;
  assign cap_acc      = in_valid && (state_q == S_CAPTURE);
  assign exp_wr       = exp_we && idle_or_done;

  // Run control: skip the filter fill, then capture DEPTH samples.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      wptr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            skip_q  <= '0;
            wptr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= (SKIP > 0) ? S_SKIP : S_CAPTURE;
          end
        end
        S_SKIP: begin
          if (in_valid) begin
            skip_q <= skip_q + 1'b1;
            if (skip_q == SKIP_LAST) state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            wptr_q <= wptr_q + 1'b1;
            if (wptr_q == LAST_IDX) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Compare pipeline and run statistics; a new run clears everything.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_idx_q    <= '0;
      cap_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      s1_vld_q <= cap_acc;
      if (cap_acc) begin
        s1_data_q <= in_data;
        s1_idx_q  <= wptr_q;
      end
      if (run_start) begin
        s1_vld_q    <= 1'b0;
        cap_cnt_q   <= '0;
        err_cnt_q   <= '0;
        first_err_q <= '0;
      end else if (s1_vld_q) begin
        cap_cnt_q <= cap_cnt_q + 1'b1;
        if (s1_data_q != exp_rd) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          if (err_cnt_q == '0) first_err_q <= s1_idx_q;
        end
      end
    end
  end

  // Expected vectors; read address tracks the write pointer so the word
  // for the accepted sample is registered on the same edge as the sample.
  fir_cap_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) EXP_MEM (
    .clk_i   (clk100),
    .rst_ni  (rstn),
    .we_i    (exp_wr),
    .waddr_i (exp_addr),
    .wdata_i (exp_data),
    .raddr_i (wptr_q),
    .rdata_o (exp_rd)
  );

  // Captured samples, read back by the host on rd_addr.
  fir_cap_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) CAP_MEM (
    .clk_i   (clk100),
    .rst_ni  (rstn),
    .we_i    (cap_acc),
    .waddr_i (wptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign cap_cnt   = cap_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;

endmodule
